bcd_serial_add_ctrl: RTL and testbench

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_serial_add_ctrl.sv | 92 +++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial packed-BCD adder, one digit per clock, least significant first.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a_in,
  input  logic [4*DIGITS-1:0] b_in,
  input  logic                c_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s_out,
  output logic                c_out,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t         state_q;
  logic [W-1:0]   a_q, b_q, acc_q, s_q;
  logic [IW-1:0]  idx_q;
  logic           carry_q, c_q, err_q, busy_q, done_q;
  logic [4:0]     t, t_adj;
  logic [3:0]     dig;
  logic           cy, bad, last;
  logic [W-1:0]   acc_d;
  // Operands shift right each ADD cycle, so the active digit is always in [3:0];
  // result digits enter at the top of acc and reach their final slot after DIGITS shifts.
  always_comb begin
    t     = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
    cy    = t > 5'd9;
    t_adj = t + 5'd6;
    dig   = cy ? t_adj[3:0] : t[3:0];
    bad   = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
    acc_d = (acc_q >> 4) | (W'(dig) << (W - 4));
    last  = idx_q == IW'(DIGITS - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a_in;
          b_q     <= b_in;
          carry_q <= c_in;
          acc_q   <= '0;
          idx_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ADD;
        end
        ADD: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= cy;
          acc_q   <= acc_d;
          idx_q   <= idx_q + IW'(1);
          if (bad) err_q <= 1'b1;
          if (last) begin
            s_q     <= acc_d;
            c_q     <= cy;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy  = busy_q;
  assign done  = done_q;
  assign s_out = s_q;
  assign c_out = c_q;
  assign err   = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed bench with a result scoreboard for the serial BCD adder.
module tb_bcd_serial_add_ctrl;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        e;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n, start, c_in;
  logic [15:0] a_in, b_in;
  logic        busy, done, c_out, err;
  logic [15:0] s_out;
  exp_t        sb[$];
  int          vecs = 0, errs = 0;
  int          lat, bc, dcnt;
  time         t1, t2;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .busy(busy), .done(done), .s_out(s_out), .c_out(c_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t r;
    int   cy, t, da, db;
    r  = '0;
    cy = int'(c);
    for (int i = 0; i < 4; i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) r.e = 1'b1;
      t = da + db + cy;
      if (t > 9) begin
        r.s[4*i +: 4] = 4'((t + 6) % 16);
        cy = 1;
      end else begin
        r.s[4*i +: 4] = 4'(t);
        cy = 0;
      end
    end
    r.c = cy[0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      chk("mon_sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mon_sum", s_out, e.s);
        chk("mon_carry", c_out, e.c);
        chk("mon_err", err, e.e);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    c_in  = c;
    start = 1'b1;
    sb.push_back(model(a, b, c));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges from acceptance to done; s_out/c_out must stay frozen meanwhile.
  task automatic wait_done(output int l, output int b);
    logic [16:0] hold;
    hold = {s_out, c_out};
    l = 0;
    b = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      l++;
      if (busy) b++;
      if (done) break;
      chk("hold_outputs", {s_out, c_out}, hold);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    c_in  = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {busy, done, s_out, c_out, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h1234, 16'h5678, 1'b0);
    wait_done(lat, bc);
    chk("basic_latency", lat, 5);
    chk("basic_busy_cycles", bc, 5);
    chk("basic_sum", s_out, 16'h6912);
    chk("basic_carry", c_out, 0);
    chk("basic_err", err, 0);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 0);

    issue(16'h9999, 16'h0001, 1'b0);
    wait_done(lat, bc);
    chk("ripple_latency", lat, 5);
    chk("ripple_sum", s_out, 16'h0000);
    chk("ripple_carry", c_out, 1);

    issue(16'h9999, 16'h9999, 1'b1);
    wait_done(lat, bc);
    chk("max_sum", s_out, 16'h9999);
    chk("max_carry", c_out, 1);

    @(negedge clk);
    a_in  = 16'h1111;
    b_in  = 16'h2222;
    c_in  = 1'b0;
    start = 1'b1;
    sb.push_back(model(16'h1111, 16'h2222, 1'b0));
    @(posedge clk);
    #1;
    a_in = 16'h9999;
    b_in = 16'h9999;
    c_in = 1'b1;
    wait_done(lat, bc);
    start = 1'b0;
    chk("held_start_latency", lat, 5);
    chk("held_start_sum", s_out, 16'h3333);
    chk("held_start_carry", c_out, 0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("held_start_single_result", dcnt, 0);

    @(negedge clk);
    a_in  = 16'h1234;
    b_in  = 16'h5678;
    c_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {busy, done, s_out, c_out, err}, 0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    issue(16'h0042, 16'h0058, 1'b0);
    wait_done(lat, bc);
    chk("post_reset_latency", lat, 5);
    chk("post_reset_sum", s_out, 16'h0100);

    issue(16'h12A4, 16'h0000, 1'b0);
    wait_done(lat, bc);
    chk("invalid_err", err, 1);
    issue(16'h0005, 16'h0004, 1'b0);
    wait_done(lat, bc);
    chk("valid_err_cleared", err, 0);
    chk("valid_sum", s_out, 16'h0009);

    issue(16'h4321, 16'h1111, 1'b0);
    wait_done(lat, bc);
    t1 = $time;
    issue(16'h0999, 16'h0001, 1'b0);
    wait_done(lat, bc);
    t2 = $time;
    chk("b2b_latency", lat, 5);
    chk("b2b_done_gap", 32'(t2 - t1), 60);
    chk("b2b_sum", s_out, 16'h1000);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
